// File: rtl/sram_write_buffer.sv
// Posted-write buffer between the cache controller and the SRAM controller.
// Writes are queued in a FIFO and drained in the background; reads wait for empty.
module sram_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic          rd_req,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [63:0]   rdata,
    output logic          ready,
    output logic          sram_write,
    output logic          sram_read,
    output logic [AW-1:0] sram_address,
    output logic [DW-1:0] sram_wdata,
    input  logic [63:0]   sram_readData,
    input  logic          sram_ready
);

    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        RDONE
    } state_t;

    state_t state, state_n;

    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;

    logic full, empty, push, pop, rd_done;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_req & ~full;
    assign pop     = (state == WRITE) & sram_ready;
    assign rd_done = (state == RDONE);
    assign ready   = ~((wr_req & full) | (rd_req & ~rd_done));

    // FIFO storage: tail entry written on every accepted write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= addr;
            fifo_data[tail] <= wdata;
        end
    end

    // Next state; a write arriving this cycle counts as non-empty so it drains next cycle
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (rd_req & empty & ~push & ~rd_done)
                    state_n = READ;
                else if (~empty | push)
                    state_n = WRITE;
            end
            WRITE: if (sram_ready) state_n = IDLE;
            READ:  if (sram_ready) state_n = RDONE;
            RDONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, pointers and registered SRAM-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            sram_write   <= 1'b0;
            sram_read    <= 1'b0;
            sram_address <= '0;
            sram_wdata   <= '0;
            rdata        <= '0;
        end else begin
            state      <= state_n;
            sram_write <= (state_n == WRITE);
            sram_read  <= (state_n == READ);
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (state == IDLE && state_n == WRITE) begin
                sram_address <= empty ? addr  : fifo_addr[head];
                sram_wdata   <= empty ? wdata : fifo_data[head];
            end
            if (state == IDLE && state_n == READ)
                sram_address <= addr;
            if (state == READ && sram_ready)
                rdata <= sram_readData;
        end
    end

endmodule

// File: tb/tb_sram_write_buffer.sv
// Testbench for sram_write_buffer: SRAM responder, queue-based reference
// model of posted writes and a memory image for read data.
module tb_sram_write_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_req = 1'b0;
    logic        rd_req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [63:0] rdata;
    logic        ready;
    logic        sram_write;
    logic        sram_read;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic [63:0] sram_readData = '0;
    logic        sram_ready = 1'b0;

    int total = 0;
    int bad = 0;

    sram_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_write(sram_write), .sram_read(sram_read),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_readData(sram_readData), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [63:0] q [$];
    logic [63:0] mem [logic [31:0]];
    logic [63:0] rd_default = 64'hFEED_FACE_0000_0000;
    logic [63:0] exp_rd = '0;
    bit          rd_fire = 0;
    bit          hold = 0;
    int          lat = 1;
    int          busy = 0;
    bit          prev_rdy = 0, prev_w = 0, prev_r = 0;
    logic [31:0] prev_a = '0, prev_d = '0;
    logic [31:0] wlog [$];

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // SRAM responder and write-order scoreboard
    always begin
        bit r0;
        bit rdy;
        @(posedge clk);
        r0 = rst;
        #1;
        rd_fire = 0;
        if (!r0 && prev_rdy) begin
            if (prev_w) begin
                chk("drain_nonempty", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    chk("drain_order", {prev_a, prev_d}, q[0]);
                    void'(q.pop_front());
                end
                mem[prev_a] = {32'h0, prev_d};
                wlog.push_back(prev_a);
            end
            if (prev_r) rd_fire = 1;
            chk("idle_bubble", {62'd0, sram_write, sram_read}, 64'd0);
        end
        if (sram_write && sram_read)
            chk("excl_wr_rd", 64'd1, 64'd0);
        if (sram_read && !prev_r)
            chk("read_after_drain", 64'(q.size()), 64'd0);
        rdy = 0;
        if (sram_write || sram_read) begin
            busy++;
            if (busy >= lat && !hold) begin
                rdy = 1;
                busy = 0;
                if (sram_read) begin
                    exp_rd = mem.exists(sram_address) ? mem[sram_address] : rd_default;
                    sram_readData = exp_rd;
                end
            end
        end else begin
            busy = 0;
        end
        sram_ready = rdy;
        prev_rdy = rdy;
        prev_w = sram_write;
        prev_r = sram_read;
        prev_a = sram_address;
        prev_d = sram_wdata;
    end

    // All tasks start and end at the drive point (1 after posedge)
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bit acc;
        int n = 0;
        wr_req = 1; addr = a; wdata = d;
        forever begin
            #1;
            acc = (q.size() < DEPTH);
            chk("wr_ready", 64'(ready), 64'(acc));
            if (acc) q.push_back({a, d});
            @(posedge clk); #1;
            if (acc) break;
            if (++n > 500) begin
                chk("wr_timeout", 64'd1, 64'd0);
                break;
            end
        end
        wr_req = 0;
    endtask

    task automatic do_read(input logic [31:0] a, output int waited, output int rcnt);
        bit f;
        waited = 0;
        rcnt = 0;
        rd_req = 1; addr = a;
        forever begin
            #1;
            f = rd_fire;
            if (sram_read) rcnt++;
            chk("rd_ready", 64'(ready), 64'(f));
            if (f) chk("rd_data", rdata, exp_rd);
            @(posedge clk); #1;
            if (f) break;
            waited++;
            if (waited > 500) begin
                chk("rd_timeout", 64'd1, 64'd0);
                break;
            end
        end
        rd_req = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            chk("idle_ready", 64'(ready), 64'd1);
            @(posedge clk); #1;
        end
    endtask

    task automatic set_cfg(input bit h, input int l);
        #1;
        hold = h;
        lat = l;
        @(posedge clk); #1;
    endtask

    task automatic wait_empty();
        int n = 0;
        forever begin
            #1;
            if (q.size() == 0 && !sram_write && !sram_read) break;
            @(posedge clk); #1;
            if (++n > 500) begin
                chk("drain_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; wr_req = 0; rd_req = 0;
        @(posedge clk); #1;
        rst = 0;
        q.delete();
    endtask

    initial begin
        int w, rc, k;
        // Reset values
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_sram_write", 64'(sram_write), 64'd0);
        chk("rst_sram_read", 64'(sram_read), 64'd0);
        chk("rst_sram_address", 64'(sram_address), 64'd0);
        chk("rst_sram_wdata", 64'(sram_wdata), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        @(posedge clk); #1;

        // Single write, drained next cycle
        set_cfg(0, 3);
        do_write(32'h400, 32'hDEADBEEF);
        #1;
        chk("t1_sram_write", 64'(sram_write), 64'd1);
        chk("t1_sram_address", 64'(sram_address), 64'h400);
        chk("t1_sram_wdata", 64'(sram_wdata), 64'hDEADBEEF);
        @(posedge clk); #1;
        wait_empty();

        // Fill with SRAM stalled; fifth write waits for the first pop
        set_cfg(1, 1);
        wlog.delete();
        for (int i = 0; i < 4; i++)
            do_write(32'h400 + 32'(4 * i), $urandom);
        wr_req = 1; addr = 32'h410; wdata = 32'h5555AAAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_full_stall", 64'(ready), 64'd0);
            @(posedge clk); #1;
        end
        #1;
        hold = 0;
        chk("t2_full_stall", 64'(ready), 64'd0);
        @(posedge clk); #1;
        do_write(32'h410, 32'h5555AAAA);
        wait_empty();
        chk("t2_log_size", 64'(wlog.size()), 64'd5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            chk("t2_log_addr", 64'(wlog[i]), 64'(32'h400 + 32'(4 * i)));

        // Read behind two posted writes
        set_cfg(0, 3);
        do_write(32'h400, 32'hDEADBEEF);
        do_write(32'h404, 32'h12345678);
        do_read(32'h400, w, rc);
        chk("t3_rdata", rdata, 64'h0000_0000_DEAD_BEEF);
        idle(1);

        // Read on an empty buffer, 2-cycle SRAM
        rd_default = 64'h0123_4567_89AB_CDEF;
        set_cfg(0, 2);
        do_read(32'h800, w, rc);
        chk("t4_stall_cycles", 64'(w), 64'd3);
        chk("t4_sram_read_cycles", 64'(rc), 64'd2);
        chk("t4_rdata", rdata, 64'h0123_4567_89AB_CDEF);
        idle(2);
        chk("t4_rdata_hold", rdata, 64'h0123_4567_89AB_CDEF);

        // Back-to-back writes overlapping drain, pointers wrap
        set_cfg(0, 1);
        for (int i = 0; i < DEPTH + 2; i++)
            do_write(32'h500 + 32'(4 * i), $urandom);
        wait_empty();

        // Reset during WRITE with three buffered entries
        set_cfg(1, 1);
        for (int i = 0; i < 3; i++)
            do_write(32'h600 + 32'(4 * i), $urandom);
        #1;
        chk("t6_in_write", 64'(sram_write), 64'd1);
        @(posedge clk); #1;
        do_reset();
        #1;
        chk("t6_sram_write", 64'(sram_write), 64'd0);
        chk("t6_ready", 64'(ready), 64'd1);
        hold = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t6_no_stale", 64'(sram_write), 64'd0);
            @(posedge clk); #1;
        end

        // Randomized mix of writes, reads and idle cycles
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 9);
            if ($urandom_range(0, 15) == 0)
                set_cfg(0, $urandom_range(1, 4));
            if (k < 6)
                do_write(32'h400 + 32'(4 * $urandom_range(0, 7)), $urandom);
            else if (k < 8)
                do_read(32'h400 + 32'(4 * $urandom_range(0, 9)), w, rc);
            else
                idle($urandom_range(1, 2));
        end
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
